// File: rtl/maxpool_pkg.sv
// Shared constants and types for the max-pooling feeder: default geometry,
// quadrant write-strobe encodings and the feeder state enum.
package maxpool_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned ARRAY_SIZE = 9;

  localparam logic [3:0] Q_TL = 4'b0001;
  localparam logic [3:0] Q_TR = 4'b0010;
  localparam logic [3:0] Q_BL = 4'b0100;
  localparam logic [3:0] Q_BR = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    POOL
  } feeder_state_e;

  function automatic logic [3:0] quadrant(input logic row_odd, input logic col_odd);
    case ({row_odd, col_odd})
      2'b00:   return Q_TL;
      2'b01:   return Q_TR;
      2'b10:   return Q_BL;
      default: return Q_BR;
    endcase
  endfunction

endpackage

// File: rtl/maxpool_feeder_lane.sv
// One channel lane of the feeder: optional ReLU (MAXPOOL_FEEDER_RELU_EN)
// followed by the data_out slice register, loaded on each accepted pixel.
module maxpool_feeder_lane #(
  parameter int unsigned data_size = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic [data_size-1:0] d_in,
  output logic [data_size-1:0] d_out
);

  logic [data_size-1:0] pix;
  logic [data_size-1:0] data_d;
  logic [data_size-1:0] data_q;

  always_comb begin
`ifdef MAXPOOL_FEEDER_RELU_EN
    pix = d_in[data_size-1] ? '0 : d_in;
`else
    pix = d_in;
`endif
    data_d = load ? pix : data_q;
  end

  always_ff @(posedge clk) begin
    if (!clear) data_q <= '0;
    else        data_q <= data_d;
  end

  assign d_out = data_q;

endmodule

// File: rtl/maxpool_feeder.sv
// Routes a raster-scan pixel stream into the 2x2 quadrant FIFOs of the pooling
// array, then runs pooling until all lanes finish. Optional ReLU: MAXPOOL_FEEDER_RELU_EN.
module maxpool_feeder
  import maxpool_pkg::*;
#(
  parameter int unsigned data_size  = DATA_SIZE,
  parameter int unsigned array_size = ARRAY_SIZE,
  parameter int unsigned img_width  = 8,
  parameter int unsigned img_height = 8
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [data_size*array_size-1:0] in_data,
  input  logic [4*array_size-1:0]         full,
  output logic [data_size*array_size-1:0] data_out,
  output logic [4*array_size-1:0]         sel,
  output logic [array_size-1:0]           pool_en,
  input  logic [array_size-1:0]           pool_done,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned CW = $clog2(img_width);
  localparam int unsigned RW = $clog2(img_height);
  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

  if ((img_width % 2) != 0 || img_width < 2 || (img_height % 2) != 0 || img_height < 2)
    begin : g_bad_geometry
      $error("maxpool_feeder: img_width and img_height must be even and >= 2");
    end

  feeder_state_e           state_d, state_q;
  logic [CW-1:0]           col_d, col_q;
  logic [RW-1:0]           row_d, row_q;
  logic [4*array_size-1:0] sel_d, sel_q;
  logic [array_size-1:0]   pool_en_d, pool_en_q;
  logic                    busy_d, busy_q;
  logic                    frame_done_d, frame_done_q;
  logic                    accept;

  // Any full flag stalls every lane; clear gating keeps in_ready low during reset.
  assign in_ready = clear & (state_q == STREAM) & ~|full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        col_d   = '0;
        row_d   = '0;
      end
      STREAM: if (accept) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) state_d = FLUSH;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      FLUSH:   state_d = POOL;
      POOL:    if (&pool_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sel_d        = accept ? {array_size{quadrant(row_q[0], col_q[0])}} : '0;
    // Outputs decoded from the next state so they line up with state_q.
    pool_en_d    = (state_d == POOL) ? '1 : '0;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == POOL) && (&pool_done);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      sel_q        <= '0;
      pool_en_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      sel_q        <= sel_d;
      pool_en_q    <= pool_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    maxpool_feeder_lane #(
      .data_size(data_size)
    ) u_lane (
      .clk  (clk),
      .clear(clear),
      .load (accept),
      .d_in (in_data[data_size*i +: data_size]),
      .d_out(data_out[data_size*i +: data_size])
    );
  end

  assign sel        = sel_q;
  assign pool_en    = pool_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_feeder.sv
// Directed self-checking bench for maxpool_feeder with a 4x4 frame and 9 lanes.
module tb_maxpool_feeder;

  localparam int DW = 16;
  localparam int AS = 9;
  localparam int W  = 4;
  localparam int H  = 4;

  logic              clk = 1'b0;
  logic              clear;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DW*AS-1:0]  in_data;
  logic [4*AS-1:0]   full;
  logic [DW*AS-1:0]  data_out;
  logic [4*AS-1:0]   sel;
  logic [AS-1:0]     pool_en;
  logic [AS-1:0]     pool_done;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int errors = 0;

  maxpool_feeder #(
    .data_size (DW),
    .array_size(AS),
    .img_width (W),
    .img_height(H)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .full      (full),
    .data_out  (data_out),
    .sel       (sel),
    .pool_en   (pool_en),
    .pool_done (pool_done),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*AS-1:0] pix(input int r, input int c);
    logic [DW*AS-1:0] v;
    for (int i = 0; i < AS; i++) v[DW*i +: DW] = DW'(16*r + 4*c + i);
    return v;
  endfunction

  function automatic logic [4*AS-1:0] exp_sel(input int r, input int c);
    logic [4*AS-1:0] v;
    logic [3:0] nib;
    nib = 4'b0001 << (2*(r%2) + (c%2));
    for (int i = 0; i < AS; i++) v[4*i +: 4] = nib;
    return v;
  endfunction

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    full = '0; pool_done = '0;
    tick(); tick();
    checks++;
    if ({in_ready, busy, frame_done} !== 3'b000 || sel !== '0 || pool_en !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b busy=%b frame_done=%b sel=%h pool_en=%h data_out=%h required all zero",
               in_ready, busy, frame_done, sel, pool_en, data_out);
    end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_enter: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        in_valid = 1'b1;
        in_data  = pix(r, c);
        tick();
        checks++;
        if (sel !== exp_sel(r, c) || data_out !== pix(r, c)) begin
          errors++;
          $display("FAIL frame_px r%0d c%0d: sel=%h data_out=%h required sel=%h data_out=%h",
                   r, c, sel, data_out, exp_sel(r, c), pix(r, c));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pool_en !== '0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush: pool_en=%h busy=%b in_ready=%b required 0 1 0", pool_en, busy, in_ready);
    end
    tick();
    checks++;
    if (pool_en !== 9'h1ff || sel !== '0) begin
      errors++;
      $display("FAIL pool_enter: pool_en=%h sel=%h required 1ff 0", pool_en, sel);
    end
  endtask

  task automatic test_pool_exit();
    pool_done = 9'h1fe;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (pool_en !== 9'h1ff || frame_done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pool_hold %0d: pool_en=%h frame_done=%b busy=%b required 1ff 0 1",
                 k, pool_en, frame_done, busy);
      end
    end
    pool_done = 9'h1ff;
    tick();
    pool_done = '0;
    checks++;
    if (pool_en !== '0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pool_exit: pool_en=%h frame_done=%b busy=%b required 0 1 0", pool_en, frame_done, busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: frame_done=%b required 0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < W*H; p++) begin
      in_valid = 1'b1;
      in_data  = pix(p / W, p % W);
      if (p == 5) begin
        full[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready %0d: in_ready=%b required 0", k, in_ready);
          end
          tick();
          checks++;
          if (sel !== '0 || data_out !== pix(1, 0)) begin
            errors++;
            $display("FAIL stall_hold %0d: sel=%h data_out=%h required sel=0 data_out=%h",
                     k, sel, data_out, pix(1, 0));
          end
        end
        full[5] = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall_release: in_ready=%b required 1", in_ready);
        end
      end
      tick();
      checks++;
      if (sel !== exp_sel(p / W, p % W) || data_out !== pix(p / W, p % W)) begin
        errors++;
        $display("FAIL bp_px %0d: sel=%h data_out=%h required sel=%h data_out=%h",
                 p, sel, data_out, exp_sel(p / W, p % W), pix(p / W, p % W));
      end
    end
    in_valid  = 1'b0;
    pool_done = 9'h1ff;
    tick();
    checks++;
    if (pool_en !== 9'h1ff || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL bp_pool: pool_en=%h frame_done=%b required 1ff 0", pool_en, frame_done);
    end
    tick();
    pool_done = '0;
    checks++;
    if (pool_en !== '0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_pool_1cyc: pool_en=%h frame_done=%b busy=%b required 0 1 0", pool_en, frame_done, busy);
    end
    tick();
  endtask

  task automatic test_ignored_and_reset_mid();
    in_valid = 1'b1;
    in_data  = pix(2, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (sel !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid %0d: sel=%h busy=%b in_ready=%b required 0 0 0", k, sel, busy, in_ready);
      end
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = pix(0, c);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    checks++;
    if (sel !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_start: sel=%h busy=%b required 0 1", sel, busy);
    end
    in_valid = 1'b1;
    in_data  = pix(0, 3);
    tick();
    checks++;
    if (sel !== exp_sel(0, 3)) begin
      errors++;
      $display("FAIL stream_start_cnt: sel=%h required %h", sel, exp_sel(0, 3));
    end
    in_data = pix(1, 0);
    tick();
    clear = 1'b0;
    in_data = pix(1, 1);
    tick();
    checks++;
    if ({in_ready, busy, frame_done} !== 3'b000 || sel !== '0 || pool_en !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b busy=%b frame_done=%b sel=%h pool_en=%h data_out=%h required all zero",
               in_ready, busy, frame_done, sel, pool_en, data_out);
    end
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < W*H; p++) begin
      in_valid = 1'b1;
      in_data  = pix(p / W, p % W);
      tick();
      checks++;
      if (sel !== exp_sel(p / W, p % W) || data_out !== pix(p / W, p % W)) begin
        errors++;
        $display("FAIL restart_px %0d: sel=%h data_out=%h required sel=%h data_out=%h",
                 p, sel, data_out, exp_sel(p / W, p % W), pix(p / W, p % W));
      end
    end
    in_data = pix(3, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (sel !== '0 || data_out !== pix(3, 3)) begin
        errors++;
        $display("FAIL pool_valid %0d: sel=%h data_out=%h required sel=0 data_out=%h",
                 k, sel, data_out, pix(3, 3));
      end
    end
    in_valid  = 1'b0;
    pool_done = 9'h1ff;
    tick();
    pool_done = '0;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_exit: busy=%b frame_done=%b required 0 1", busy, frame_done);
    end
    tick();
  endtask

  task automatic test_relu();
    logic [DW*AS-1:0] d;
    logic [DW-1:0] exp0;
`ifdef MAXPOOL_FEEDER_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hfff0;
`endif
    d = '0;
    d[15:0]  = 16'hfff0;
    d[31:16] = 16'h0007;
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    checks++;
    if (data_out[15:0] !== exp0 || data_out[31:16] !== 16'h0007) begin
      errors++;
      $display("FAIL relu: lane0=%h lane1=%h required lane0=%h lane1=0007", data_out[15:0], data_out[31:16], exp0);
    end
    clear = 1'b0;
    tick();
    clear = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pool_exit();
    test_backpressure();
    test_ignored_and_reset_mid();
    test_relu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
